// File: rtl/mem_write_checker_pkg.sv
// Shared types for the store-sequence checker: scalar aliases, FSM states and failure codes.
package mem_write_checker_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ADDR    = 2'd1,
    FC_DATA    = 2'd2,
    FC_TIMEOUT = 2'd3
  } fail_code_t;

endpackage

// File: rtl/mem_write_checker_exp_table.sv
// Expected-write table: one synchronous write port, one asynchronous read port, no reset.
module exp_table
  import mem_write_checker_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 4,
  parameter int IDX_W   = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [ADDR_W-1:0] addr_mem [NUM_EXP];
  logic [DATA_W-1:0] data_mem [NUM_EXP];

  always_ff @(posedge clk) begin
    if (we && (int'(widx) < NUM_EXP)) begin
      addr_mem[widx] <= waddr;
      data_mem[widx] <= wdata;
    end
  end

  // Out-of-range reads (non-power-of-two depth) return zero.
  always_comb begin
    raddr = '0;
    rdata = '0;
    if (int'(ridx) < NUM_EXP) begin
      raddr = addr_mem[ridx];
      rdata = data_mem[ridx];
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Watches a store stream during a run and checks it against a programmed ordered list of
// expected (address, data) writes, reporting pass, or the first failure and its cause.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int NUM_EXP = 4,
  parameter  int TIMEOUT = 20,
  localparam int IDX_W   = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int CNT_W   = $clog2(NUM_EXP) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataaddr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [ADDR_W-1:0] scratch_addr,
  input  logic              start,
  input  logic              clear,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  match_count
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_q, state_nxt;
  fail_code_t        fc_q, fc_nxt;
  logic [ADDR_W-1:0] fa_nxt;
  logic [DATA_W-1:0] fd_nxt;
  logic [CNT_W-1:0]  match_nxt, match_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt, cnt_clamped;
  logic [TO_W-1:0]   cyc_q, cyc_nxt;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  u1                 tbl_we;
  u1                 decided;

  exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_EXP(NUM_EXP),
    .IDX_W  (IDX_W)
  ) u_exp_table (
    .clk  (clk),
    .we   (tbl_we),
    .widx (cfg_idx),
    .waddr(cfg_addr),
    .wdata(cfg_data),
    .ridx (match_count[IDX_W-1:0]),
    .raddr(exp_addr),
    .rdata(exp_data)
  );

  assign match_inc   = match_count + CNT_W'(1);
  assign cnt_clamped = (cfg_count > CNT_W'(NUM_EXP)) ? CNT_W'(NUM_EXP) : cfg_count;
  assign fail_code   = fc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fc_q        <= FC_NONE;
      fail_addr   <= '0;
      fail_data   <= '0;
      match_count <= '0;
      cnt_q       <= '0;
      cyc_q       <= '0;
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      fc_q        <= fc_nxt;
      fail_addr   <= fa_nxt;
      fail_data   <= fd_nxt;
      match_count <= match_nxt;
      cnt_q       <= cnt_nxt;
      cyc_q       <= cyc_nxt;
      busy        <= (state_nxt == ST_RUN);
      pass        <= (state_nxt == ST_PASS);
      fail        <= (state_nxt == ST_FAIL);
    end
  end

  always_comb begin
    state_nxt = state_q;
    fc_nxt    = fc_q;
    fa_nxt    = fail_addr;
    fd_nxt    = fail_data;
    match_nxt = match_count;
    cnt_nxt   = cnt_q;
    cyc_nxt   = cyc_q;
    tbl_we    = 1'b0;
    decided   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tbl_we = cfg_we && !reset;
        if (start) begin
          cnt_nxt   = cnt_clamped;
          match_nxt = '0;
          cyc_nxt   = '0;
          state_nxt = (cnt_clamped == '0) ? ST_PASS : ST_RUN;
        end
      end
      ST_RUN: begin
        cyc_nxt = cyc_q + TO_W'(1);
        if (memwrite) begin
          // Expected address is tested first so a scratch alias of it still counts.
          if (dataaddr == exp_addr) begin
            if (writedata == exp_data) begin
              match_nxt = match_inc;
              if (match_inc == cnt_q) begin
                state_nxt = ST_PASS;
                decided   = 1'b1;
              end
            end else begin
              state_nxt = ST_FAIL;
              fc_nxt    = FC_DATA;
              fa_nxt    = dataaddr;
              fd_nxt    = writedata;
              decided   = 1'b1;
            end
          end else if (dataaddr != scratch_addr) begin
            state_nxt = ST_FAIL;
            fc_nxt    = FC_ADDR;
            fa_nxt    = dataaddr;
            fd_nxt    = writedata;
            decided   = 1'b1;
          end
        end
        // A write that ends the run wins over expiry in the same cycle.
        if (!decided && (cyc_q == TO_W'(TIMEOUT - 1))) begin
          state_nxt = ST_FAIL;
          fc_nxt    = FC_TIMEOUT;
          fa_nxt    = '0;
          fd_nxt    = '0;
          match_nxt = match_count;
        end
      end
      ST_PASS, ST_FAIL: begin
        if (clear) begin
          state_nxt = ST_IDLE;
          fc_nxt    = FC_NONE;
          fa_nxt    = '0;
          fd_nxt    = '0;
          match_nxt = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker with immediate-assertion checks against hand-computed values.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataaddr = '0;
  logic [31:0] writedata = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic [2:0]  cfg_count = '0;
  logic [31:0] scratch_addr = '0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        busy, pass, fail;
  logic [1:0]  fail_code;
  logic [31:0] fail_addr, fail_data;
  logic [2:0]  match_count;

  int n_cmp = 0;
  int n_bad = 0;
  int ticks, busy_cycles;

  mem_write_checker #(
    .ADDR_W (32),
    .DATA_W (32),
    .NUM_EXP(4),
    .TIMEOUT(20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataaddr    (dataaddr),
    .writedata   (writedata),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_count   (cfg_count),
    .scratch_addr(scratch_addr),
    .start       (start),
    .clear       (clear),
    .busy        (busy),
    .pass        (pass),
    .fail        (fail),
    .fail_code   (fail_code),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataaddr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_code", 64'(fail_code), 64'd0);
    chk("rst_faddr", 64'(fail_addr), 64'd0);
    chk("rst_fdata", 64'(fail_data), 64'd0);
    chk("rst_match", 64'(match_count), 64'd0);

    // Scratch write ignored, then the single expected write passes
    cfg(2'd0, 32'd84, 32'd7);
    cfg_count = 3'd1; scratch_addr = 32'd80;
    do_start();
    chk("a_busy", 64'(busy), 64'd1);
    wr(32'd80, 32'd3);
    chk("a_scratch_busy", 64'(busy), 64'd1);
    chk("a_scratch_pass", 64'(pass), 64'd0);
    wr(32'd84, 32'd7);
    chk("a_pass", 64'(pass), 64'd1);
    chk("a_busy_lo", 64'(busy), 64'd0);
    chk("a_match", 64'(match_count), 64'd1);
    wr(32'd88, 32'd7);
    chk("a_hold_pass", 64'(pass), 64'd1);
    chk("a_hold_fail", 64'(fail), 64'd0);
    do_clear();
    chk("a_clr_pass", 64'(pass), 64'd0);
    chk("a_clr_match", 64'(match_count), 64'd0);

    // Unexpected address
    do_start();
    wr(32'd88, 32'd7);
    chk("b_fail", 64'(fail), 64'd1);
    chk("b_code", 64'(fail_code), 64'd1);
    chk("b_faddr", 64'(fail_addr), 64'd88);
    chk("b_fdata", 64'(fail_data), 64'd7);
    do_clear();
    chk("b_clr_code", 64'(fail_code), 64'd0);
    chk("b_clr_faddr", 64'(fail_addr), 64'd0);

    // Data mismatch; start while in FAIL is ignored
    do_start();
    wr(32'd84, 32'd6);
    chk("c_fail", 64'(fail), 64'd1);
    chk("c_code", 64'(fail_code), 64'd2);
    chk("c_faddr", 64'(fail_addr), 64'd84);
    chk("c_fdata", 64'(fail_data), 64'd6);
    do_start();
    chk("c_start_ign", 64'(fail), 64'd1);
    do_clear();

    // Timeout: no writes, fail exactly 20 edges after the start edge
    do_start();
    ticks = 0; busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cycles++;
      if (fail) break;
      tick();
      ticks++;
    end
    chk("d_ticks", 64'(ticks), 64'd20);
    chk("d_busy_cycles", 64'(busy_cycles), 64'd20);
    chk("d_code", 64'(fail_code), 64'd3);
    chk("d_faddr", 64'(fail_addr), 64'd0);
    chk("d_fdata", 64'(fail_data), 64'd0);
    do_clear();

    // Final matching write lands on the timeout-expiry cycle
    cfg(2'd0, 32'd0, 32'd1);
    cfg(2'd1, 32'd4, 32'd2);
    cfg(2'd2, 32'd8, 32'd3);
    cfg_count = 3'd3;
    do_start();
    wr(32'd0, 32'd1);
    wr(32'd4, 32'd2);
    for (int i = 0; i < 17; i++) tick();
    chk("e_busy", 64'(busy), 64'd1);
    chk("e_match2", 64'(match_count), 64'd2);
    wr(32'd8, 32'd3);
    chk("e_pass", 64'(pass), 64'd1);
    chk("e_fail", 64'(fail), 64'd0);
    chk("e_match3", 64'(match_count), 64'd3);
    do_clear();

    // Reset mid-run aborts; rerun starts at entry 0
    do_start();
    wr(32'd0, 32'd1);
    chk("f_match1", 64'(match_count), 64'd1);
    reset = 1'b1; memwrite = 1'b1; dataaddr = 32'd4; writedata = 32'd2;
    tick();
    reset = 1'b0; memwrite = 1'b0;
    chk("f_rst_busy", 64'(busy), 64'd0);
    chk("f_rst_pf", 64'({pass, fail}), 64'd0);
    chk("f_rst_match", 64'(match_count), 64'd0);
    cfg(2'd0, 32'd0, 32'd1);
    cfg(2'd1, 32'd4, 32'd2);
    cfg(2'd2, 32'd8, 32'd3);
    do_start();
    wr(32'd0, 32'd1);
    chk("f_rerun_match", 64'(match_count), 64'd1);
    wr(32'd4, 32'd2);
    wr(32'd8, 32'd3);
    chk("f_rerun_pass", 64'(pass), 64'd1);
    do_clear();

    // Zero-length run passes immediately
    cfg_count = 3'd0;
    do_start();
    chk("g_pass", 64'(pass), 64'd1);
    chk("g_match", 64'(match_count), 64'd0);
    do_clear();

    // Scratch aliasing the expected address; cfg_we and clear ignored in RUN
    cfg(2'd0, 32'd80, 32'd5);
    cfg_count = 3'd1; scratch_addr = 32'd80;
    do_start();
    cfg(2'd0, 32'd90, 32'd9);
    do_clear();
    chk("h_clear_run", 64'(busy), 64'd1);
    wr(32'd80, 32'd5);
    chk("h_alias_pass", 64'(pass), 64'd1);
    do_clear();

    // Reset beats start in the same cycle
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("i_rst_start", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
